// File: rtl/vga_pkg.sv
//==============================================================================
// Module   : vga_pkg
// Brief    : XVGA (1024x768@60, 65 MHz) timing constants and shared types.
// Revision : 1.0
//==============================================================================
`default_nettype none

package vga_pkg;

  localparam int XVGA_H_ACTIVE = 1024;
  localparam int XVGA_H_FP     = 24;
  localparam int XVGA_H_SYNC   = 136;
  localparam int XVGA_H_BP     = 160;
  localparam int XVGA_V_ACTIVE = 768;
  localparam int XVGA_V_FP     = 3;
  localparam int XVGA_V_SYNC   = 6;
  localparam int XVGA_V_BP     = 29;

  localparam int XVGA_H_TOTAL = XVGA_H_ACTIVE + XVGA_H_FP + XVGA_H_SYNC + XVGA_H_BP;
  localparam int XVGA_V_TOTAL = XVGA_V_ACTIVE + XVGA_V_FP + XVGA_V_SYNC + XVGA_V_BP;

  localparam int XVGA_H_SYNC_START = XVGA_H_ACTIVE + XVGA_H_FP;
  localparam int XVGA_H_SYNC_END   = XVGA_H_SYNC_START + XVGA_H_SYNC;
  localparam int XVGA_V_SYNC_START = XVGA_V_ACTIVE + XVGA_V_FP;
  localparam int XVGA_V_SYNC_END   = XVGA_V_SYNC_START + XVGA_V_SYNC;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

endpackage

`default_nettype wire

// File: rtl/sync_delay_line.sv
//==============================================================================
// Module   : sync_delay_line
// Brief    : WIDTH x DEPTH shift register with a per-bit reset value.
// Revision : 1.0
//==============================================================================
`default_nettype none

module sync_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (DEPTH == 0) begin : g_passthru
    logic w_unused;
    assign w_unused = &{1'b0, clk, reset_n};
    assign o_data   = i_data;
  end else begin : g_shift
    logic [WIDTH-1:0] r_stage [DEPTH];

    // Reset fills every stage so no stale sync pulse leaks out after reset
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
      end else begin
        r_stage[0] <= i_data;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_data = r_stage[DEPTH-1];
  end

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
//==============================================================================
// Module   : vga_timing_gen
// Brief    : Raster counters, registered sync/blank decode, delayed syncs, frame tick.
// Revision : 1.0
//==============================================================================
`default_nettype none

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = XVGA_H_ACTIVE,
  parameter int H_FP       = XVGA_H_FP,
  parameter int H_SYNC     = XVGA_H_SYNC,
  parameter int H_BP       = XVGA_H_BP,
  parameter int V_ACTIVE   = XVGA_V_ACTIVE,
  parameter int V_FP       = XVGA_V_FP,
  parameter int V_SYNC     = XVGA_V_SYNC,
  parameter int V_BP       = XVGA_V_BP,
  parameter int PIPE_DELAY = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [HCOUNT_W-1:0] hcount,
  output logic [VCOUNT_W-1:0] vcount,
  output logic                blank,
  output logic                hsync,
  output logic                vsync,
  output logic                hsync_d,
  output logic                vsync_d,
  output logic                blank_d,
  output logic                frame_tick,
  output logic [15:0]         frame_count
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HCOUNT_W-1:0] c_h_last       = HCOUNT_W'(c_h_total - 1);
  localparam logic [HCOUNT_W-1:0] c_h_active     = HCOUNT_W'(H_ACTIVE);
  localparam logic [HCOUNT_W-1:0] c_h_sync_start = HCOUNT_W'(H_ACTIVE + H_FP);
  localparam logic [HCOUNT_W-1:0] c_h_sync_end   = HCOUNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCOUNT_W-1:0] c_v_last       = VCOUNT_W'(c_v_total - 1);
  localparam logic [VCOUNT_W-1:0] c_v_active     = VCOUNT_W'(V_ACTIVE);
  localparam logic [VCOUNT_W-1:0] c_v_sync_start = VCOUNT_W'(V_ACTIVE + V_FP);
  localparam logic [VCOUNT_W-1:0] c_v_sync_end   = VCOUNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if (c_h_total > (1 << HCOUNT_W)) begin : g_err_h_total
    $error("vga_timing_gen: H_TOTAL %0d exceeds hcount range", c_h_total);
  end
  if (c_v_total > (1 << VCOUNT_W)) begin : g_err_v_total
    $error("vga_timing_gen: V_TOTAL %0d exceeds vcount range", c_v_total);
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_err_pipe_delay
    $error("vga_timing_gen: PIPE_DELAY %0d outside 0..7", PIPE_DELAY);
  end

  logic [HCOUNT_W-1:0] r_hcount;
  logic [VCOUNT_W-1:0] r_vcount;
  logic                r_blank;
  logic                r_hsync;
  logic                r_vsync;
  logic                r_frame_tick;
  logic [15:0]         r_frame_count;

  logic                w_h_wrap;
  logic [HCOUNT_W-1:0] w_hcount_nxt;
  logic [VCOUNT_W-1:0] w_vcount_nxt;
  logic                w_hsync_nxt;
  logic                w_vsync_nxt;
  logic                w_blank_nxt;
  logic                w_tick_nxt;
  logic [2:0]          w_delayed;

  // Flags decode the next counter value so they land in the same register
  // update as the position they describe.
  always_comb begin
    w_h_wrap     = (r_hcount == c_h_last);
    w_hcount_nxt = w_h_wrap ? '0 : r_hcount + 1'b1;
    w_vcount_nxt = r_vcount;
    if (w_h_wrap) begin
      w_vcount_nxt = (r_vcount == c_v_last) ? '0 : r_vcount + 1'b1;
    end
    w_hsync_nxt = ~((w_hcount_nxt >= c_h_sync_start) && (w_hcount_nxt < c_h_sync_end));
    w_vsync_nxt = ~((w_vcount_nxt >= c_v_sync_start) && (w_vcount_nxt < c_v_sync_end));
    w_blank_nxt = (w_hcount_nxt >= c_h_active) || (w_vcount_nxt >= c_v_active);
    w_tick_nxt  = (w_hcount_nxt == '0) && (w_vcount_nxt == c_v_active);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_blank       <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_tick  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_hcount     <= w_hcount_nxt;
      r_vcount     <= w_vcount_nxt;
      r_blank      <= w_blank_nxt;
      r_hsync      <= w_hsync_nxt;
      r_vsync      <= w_vsync_nxt;
      r_frame_tick <= w_tick_nxt;
      if (w_tick_nxt) r_frame_count <= r_frame_count + 1'b1;
    end
  end

  sync_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (3'b111)
  ) u_sync_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .i_data  ({r_hsync, r_vsync, r_blank}),
    .o_data  (w_delayed)
  );

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign blank       = r_blank;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_tick  = r_frame_tick;
  assign frame_count = r_frame_count;
  assign {hsync_d, vsync_d, blank_d} = w_delayed;

endmodule

`default_nettype wire
